// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, defaults and helpers for the
// data-memory responder and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 6;
  localparam int WAIT_DEF       = 2;
  localparam int WAIT_MAX       = 15;

  // Byte address to word index; upper bits wrap away.
  function automatic logic [31:0] word_index(
    input logic [31:0] a,
    input int unsigned dlog2
  );
    return (a >> 2) & ((32'd1 << dlog2) - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and
// registered read; contents survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Single port: a write and a read never share an edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with
// fixed wait states. DMEM_MISALIGN_CHECK_EN adds err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_STATES = WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  err
);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX)
  begin : g_ws_range
    $error("WAIT_STATES out of range 0..15");
  end

  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  zero_q, zero_d;

  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_mis;
  logic                  commit;
  logic                  arr_we;
  logic                  arr_re;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // With zero wait states the commit edge is the capture
  // edge, so the live bus is used while still in IDLE.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  // Misaligned accesses are flagged only when enabled.
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    acc_mis = (acc_addr[1:0] != 2'b00);
`else
    acc_mis = 1'b0;
`endif
  end

  assign arr_idx = DEPTH_LOG2'(
    word_index(32'(acc_addr), DEPTH_LOG2));

  // Next-state, wait counter and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    zero_d  = zero_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (commit) begin
      err_d = acc_mis;
      if (!acc_we) begin
        zero_d = acc_mis;
      end
    end
  end

  assign arr_we = commit & acc_we & ~acc_mis;
  assign arr_re = commit & ~acc_we & ~acc_mis;

  // State and captured-request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // The array read register has no reset, so a zero mask
  // covers reset and misaligned-read responses.
  assign rdata = zero_q ? '0 : arr_rdata;
  assign ack   = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors on a 2-wait-state
// instance plus a 0-wait-state instance for back-to-back.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        ack_a, busy_a, err_a;
  logic [31:0] rdata_a;
  logic        ack_b, busy_b, err_b;
  logic [31:0] rdata_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_STATES(2)) u_a (
    .clk   (clk),
    .reset (reset),
    .req   (req_a),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack_a),
    .rdata (rdata_a),
    .busy  (busy_a),
    .err   (err_a)
  );

  dmem_responder #(.WAIT_STATES(0)) u_b (
    .clk   (clk),
    .reset (reset),
    .req   (req_b),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack_b),
    .rdata (rdata_b),
    .busy  (busy_b),
    .err   (err_b)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic access(input int sel,
                        input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat,
                        output int bcnt);
    logic done;
    @(posedge clk); #1;
    we = w; addr = a; wdata = d;
    if (sel == 0) req_a = 1'b1;
    else req_b = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = 1; bcnt = 0; done = 1'b0;
    rd = '0; er = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if ((sel == 0) ? busy_a : busy_b) bcnt++;
      if ((sel == 0) ? ack_a : ack_b) begin
        done = 1'b1;
        rd = (sel == 0) ? rdata_a : rdata_b;
        er = (sel == 0) ? err_a : err_b;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("ack_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v[12];
    logic [31:0] rd;
    logic        er;
    int          lat, bcnt, k, nack;
    logic [31:0] prior20;

    v[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    v[1]  = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 32'h100, 32'h55, 32'hDEADBEEF, 1'b0};
    v[3]  = '{1'b0, 32'h000, 32'h0, 32'h55, 1'b0};
    v[4]  = '{1'b1, 32'h004, 32'hA5A5A5A5, 32'h55, 1'b0};
    v[5]  = '{1'b0, 32'h104, 32'h0, 32'hA5A5A5A5, 1'b0};
    v[6]  = '{1'b1, 32'h0FC, 32'h13579BDF,
              32'hA5A5A5A5, 1'b0};
    v[7]  = '{1'b0, 32'h1FC, 32'h0, 32'h13579BDF, 1'b0};
    v[8]  = '{1'b1, 32'h020, 32'hCAFEF00D,
              32'h13579BDF, 1'b0};
    v[9]  = '{1'b0, 32'h020, 32'h0, 32'hCAFEF00D, 1'b0};
    v[10] = '{1'b1, 32'hFFFFFFF0, 32'h0BADC0DE,
              32'hCAFEF00D, 1'b0};
    v[11] = '{1'b0, 32'h0F0, 32'h0, 32'h0BADC0DE, 1'b0};

    // Reset, start an access, then reset mid-cycle.
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    req_a = 1'b0;
    chk("busy_after_capture", 32'(busy_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    nack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_a || ack_b) nack++;
    end
    chk("idle_no_ack", 32'(nack), 32'd0);

    // Table-driven accesses on the 2-wait-state instance.
    for (int i = 0; i < 12; i++) begin
      access(0, v[i].w, v[i].a, v[i].d,
             rd, er, lat, bcnt);
      chk($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(er),
          32'(v[i].exp_er));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_busy", i), 32'(bcnt), 32'd3);
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    access(0, 1'b1, 32'h22, 32'hFFFF, rd, er, lat, bcnt);
    chk("mis_wr_err", 32'(er), 32'd1);
    chk("mis_wr_lat", 32'(lat), 32'd3);
    access(0, 1'b0, 32'h20, 32'h0, rd, er, lat, bcnt);
    chk("mis_rd_old", rd, 32'hCAFEF00D);
    chk("mis_rd_err", 32'(er), 32'd0);
    access(0, 1'b0, 32'h21, 32'h0, rd, er, lat, bcnt);
    chk("mis_rd_zero", rd, 32'h0);
    chk("mis_rd_flag", 32'(er), 32'd1);
    prior20 = 32'hCAFEF00D;
`else
    access(0, 1'b1, 32'h23, 32'h77, rd, er, lat, bcnt);
    chk("unal_wr_err", 32'(er), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, rd, er, lat, bcnt);
    chk("unal_rd_data", rd, 32'h77);
    chk("unal_rd_err", 32'(er), 32'd0);
    prior20 = 32'h77;
`endif

    // Reset during WAIT drops the pending write.
    @(posedge clk); #1;
    req_a = 1'b1; we = 1'b1;
    addr = 32'h20; wdata = 32'h1234;
    @(posedge clk); #1;
    req_a = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack_a) nack++;
    end
    #2 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack_a) nack++;
    end
    chk("abort_no_ack", 32'(nack), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, rd, er, lat, bcnt);
    chk("abort_prior", rd, prior20);

    // Zero wait states: preload, then back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      access(1, 1'b1, 32'(i * 4), 32'(i + 1),
             rd, er, lat, bcnt);
      chk($sformatf("z_pre%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("z_pre%0d_busy", i),
          32'(bcnt), 32'd1);
    end
    @(posedge clk); #1;
    req_b = 1'b1; we = 1'b0; addr = 32'h0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack%0d", c),
          32'(ack_b), 32'(c % 2));
      if (ack_b) begin
        chk($sformatf("b2b_rd%0d", k),
            rdata_b, 32'(k + 1));
        k++;
        if (k < 4) addr = 32'(k * 4);
        else req_b = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_ack", 32'(ack_b), 32'd0);
    chk("b2b_end_busy", 32'(busy_b), 32'd0);
    chk("b2b_hold", rdata_b, 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
